// File: rtl/logic_seq_pkg.sv
// Shared types for the bit-serial logic-op sequencer: opcodes, FSM states,
// and the opcode legality check used at command acceptance.
package logic_seq_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOT = 3'b011,
    OP_SHL = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'(OP_SHL);
  endfunction

endpackage

// File: rtl/logseq_shreg.sv
// Operand latch and result capture register for the sequencer; one result bit
// is written per RUN cycle at the index supplied by the FSM.
module logseq_shreg
  import logic_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             err_i,
  input  logic             cap_i,
  input  logic [IW-1:0]    idx_i,
  input  logic             bit_i,
  output logic [2:0]       op_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] res_o,
  output logic             err_o
);

  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else if (load_i) begin
      // Result clears on load so an illegal op reports all-zero data.
      op_q  <= op_i;
      a_q   <= a_i;
      b_q   <= b_i;
      res_q <= '0;
      err_q <= err_i;
    end else if (cap_i) begin
      res_q[idx_i] <= bit_i;
    end
  end

  assign op_o  = op_q;
  assign a_o   = a_q;
  assign b_o   = b_q;
  assign res_o = res_q;
  assign err_o = err_q;

endmodule

// File: rtl/logic_op_sequencer.sv
// Bit-serial sequencer driving an external 1-bit logic unit LSB first.
// Optional res_parity output when LOGSEQ_PARITY_EN is defined.
module logic_op_sequencer
  import logic_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             lu_a,
  output logic             lu_b,
  output logic             lu_opsel0,
  output logic             lu_opsel1,
  output logic             lu_opsel2,
  input  logic             lu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
`ifdef LOGSEQ_PARITY_EN
  output logic             res_parity,
`endif
  output logic             res_err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             load, cap;
  logic [2:0]       op_q, opsel;
  logic [WIDTH-1:0] a_q, b_q;

  logseq_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .op_i   (cmd_op),
    .a_i    (cmd_a),
    .b_i    (cmd_b),
    .err_i  (~op_legal(cmd_op)),
    .cap_i  (cap),
    .idx_i  (idx_q),
    .bit_i  (lu_out),
    .op_o   (op_q),
    .a_o    (a_q),
    .b_o    (b_q),
    .res_o  (res_data),
    .err_o  (res_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    load      = 1'b0;
    cap       = 1'b0;
    lu_a      = 1'b0;
    lu_b      = 1'b0;
    opsel     = 3'b000;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = op_legal(cmd_op) ? RUN : DONE;
        end
      end
      RUN: begin
        cap   = 1'b1;
        opsel = op_q;
        lu_b  = b_q[idx_q];
        // SHL reuses the unit's pass-A path with operand A delayed by one bit.
        if (op_q == 3'(OP_SHL))
          lu_a = (idx_q == '0) ? 1'b0 : a_q[IW'(idx_q - 1'b1)];
        else
          lu_a = a_q[idx_q];
        if (idx_q == LAST) state_d = DONE;
        else               idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign lu_opsel0 = opsel[0];
  assign lu_opsel1 = opsel[1];
  assign lu_opsel2 = opsel[2];

`ifdef LOGSEQ_PARITY_EN
  assign res_parity = ^res_data;
`endif

endmodule

// File: doc/logic_op_sequencer.md
LOGIC_OP_SEQUENCER -- requirements
Module: logic_op_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous reset, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  sequencer accepts command.
REQ-006 SHALL have port cmd_op  input  3  opcode: 000 AND, 001 OR, 010 XOR, 011 NOT(a), 100 SHL(a by 1), 101-111 illegal.
REQ-007 SHALL have port cmd_a  input  WIDTH  operand A.
REQ-008 SHALL have port cmd_b  input  WIDTH  operand B (ignored for NOT/SHL).
REQ-009 SHALL have ports lu_a, lu_b  output  1  serial operand bits to the bit-wide logic unit.
REQ-010 SHALL have ports lu_opsel0, lu_opsel1, lu_opsel2  output  1  unit op select, equal to cmd_op bits 0..2.
REQ-011 SHALL have port lu_out  input  1  unit result bit, combinational in the same cycle.
REQ-012 SHALL have port res_valid  output  1  result available.
REQ-013 SHALL have port res_ready  input  1  consumer accepts result.
REQ-014 SHALL have port res_data  output  WIDTH  assembled result.
REQ-015 SHALL have port res_err  output  1  illegal opcode flag, qualified by res_valid.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready, latch op/a/b, clear bit index, go RUN (legal op) or DONE (illegal op).
REQ-018 RUN: each cycle drive bit i (LSB first), sample lu_out into res_data[i] at clock edge, i++; after i=WIDTH-1 go DONE.
REQ-019 For SHL, lu_a SHALL carry a[i-1] for i>0 and 0 for i=0; unit opsel stays 100, so res_data = {a[WIDTH-2:0],0}.
REQ-020 Outside RUN, lu_a, lu_b, lu_opsel* SHALL be 0.
REQ-021 DONE: res_valid=1, res_data/res_err stable; on res_ready go IDLE; cmd_ready=0.
REQ-022 Illegal opcode: no RUN cycles, res_data=0, res_err=1.
REQ-023 Latency: legal command accepted edge N gives res_valid from cycle N+WIDTH+1; illegal gives res_valid at N+1.
REQ-024 cmd_ready SHALL be 0 in RUN and DONE; no command buffering; back-to-back throughput one command per WIDTH+2 cycles minimum.
REQ-025 res_ready held low SHALL stall in DONE indefinitely without data change.

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE, bit index 0, res_data 0, res_err 0, res_valid 0, cmd_ready 1 (after release), lu_* 0.
REQ-027 Reset mid-RUN or mid-DONE SHALL discard the command with no result emitted.

Configuration
REQ-028 Macro LOGSEQ_PARITY_EN defined: extra output res_parity (1 bit) = XOR of res_data, valid with res_valid, 0 at reset; undefined: port absent, no parity logic.

Structure
REQ-029 Package logic_seq_pkg SHALL hold opcode enum (OP_AND..OP_SHL), state enum, and opcode-legality function.
REQ-030 Sub-module logseq_shreg SHALL hold the latched operands and the result capture register; FSM and bit counter stay in logic_op_sequencer.

Verification
REQ-031 WIDTH=8, op AND, a=0xF0, b=0x3C -> res_data 0x30, res_err 0, res_valid at accept+9.
REQ-032 op SHL, a=0x81 -> lu_a sequence 0,1,0,0,0,0,0,0 LSB first; res_data 0x02.
REQ-033 op 110, a=0xFF -> res_valid next cycle, res_data 0x00, res_err 1, lu_* stay 0.
REQ-034 XOR a=0xAA b=0xFF with res_ready low 5 cycles -> res_data 0x55 held, cmd_ready 0 throughout, then IDLE.
REQ-035 rst_n pulsed low at RUN bit 4 of OR command -> no res_valid, next command NOT a=0x0F gives 0xF0.
REQ-036 LOGSEQ_PARITY_EN defined, OR a=0x01 b=0x02 -> res_data 0x03, res_parity 0.
